// File: rtl/reset_seq_sync.sv
// reset_seq_sync: synchronises the release of ARSTN into the CLK domain,
// holds reset for a minimum time, then releases NUM_CH active-low
// synchronous resets one after another with a fixed stagger. A software
// request restarts the whole sequence without touching ARSTN.
module reset_seq_sync #(
    parameter int NUM_CH            = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int STAGGER_CYCLES    = 4
) (
    input  logic              CLK,
    input  logic              ARSTN,
    input  logic              SW_RST_REQ,
    output logic [NUM_CH-1:0] SRSTN,
    output logic              RST_DONE,
    output logic [1:0]        STATE
);

    localparam int MAX_CNT = (MIN_ASSERT_CYCLES > STAGGER_CYCLES) ? MIN_ASSERT_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_syncChain;
    logic                   w_arstSyncN;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic [IDX_W-1:0]       r_chIdx;
    logic [IDX_W-1:0]       w_chIdxNext;
    logic [NUM_CH-1:0]      r_srstn;
    logic [NUM_CH-1:0]      w_srstnNext;
    logic                   r_done;
    logic                   w_doneNext;

    // Deassertion synchroniser: clears instantly, shifts a 1 in once ARSTN is released
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_arstSyncN = r_syncChain[SYNC_STAGES-1];

    // State, counters and all reset outputs live in flops so outputs never glitch
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_chIdx <= '0;
            r_srstn <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_chIdx <= w_chIdxNext;
            r_srstn <= w_srstnNext;
            r_done  <= w_doneNext;
        end
    end

    // Sequencer: hold for the minimum time, then release channels in index order
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_chIdxNext = r_chIdx;
        w_srstnNext = r_srstn;
        w_doneNext  = r_done;

        case (r_state)
            ST_HOLD: begin
                w_srstnNext = '0;
                w_doneNext  = 1'b0;
                w_chIdxNext = '0;
                if (SW_RST_REQ || !w_arstSyncN) begin
                    w_cntNext = '0;
                end else if (r_cnt == CNT_W'(MIN_ASSERT_CYCLES - 1)) begin
                    w_stateNext    = ST_RELEASE;
                    w_srstnNext    = '0;
                    w_srstnNext[0] = 1'b1;
                    w_cntNext      = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (SW_RST_REQ) begin
                    w_stateNext = ST_HOLD;
                    w_srstnNext = '0;
                    w_doneNext  = 1'b0;
                    w_cntNext   = '0;
                    w_chIdxNext = '0;
                end else if (r_cnt == CNT_W'(STAGGER_CYCLES - 1) &&
                             r_chIdx == IDX_W'(NUM_CH - 1)) begin
                    w_stateNext = ST_RUN;
                    w_doneNext  = 1'b1;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                    w_chIdxNext = r_chIdx + IDX_W'(1);
                    w_cntNext   = '0;
                    for (int i = 1; i < NUM_CH; i++) begin
                        if (IDX_W'(i) == r_chIdx + IDX_W'(1)) begin
                            w_srstnNext[i] = 1'b1;
                        end
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (SW_RST_REQ) begin
                    w_stateNext = ST_HOLD;
                    w_srstnNext = '0;
                    w_doneNext  = 1'b0;
                    w_cntNext   = '0;
                    w_chIdxNext = '0;
                end
            end

            default: begin
                w_stateNext = ST_HOLD;
                w_srstnNext = '0;
                w_doneNext  = 1'b0;
                w_cntNext   = '0;
                w_chIdxNext = '0;
            end
        endcase
    end

    assign SRSTN    = r_srstn;
    assign RST_DONE = r_done;
    assign STATE    = r_state;

endmodule

// File: tb/tb_reset_seq_sync.sv
// tb_reset_seq_sync: directed checks of reset_seq_sync with default
// parameters plus a degenerate single-channel instance sharing the inputs.
module tb_reset_seq_sync;

    logic       CLK = 1'b0;
    logic       ARSTN;
    logic       SW_RST_REQ;
    logic [3:0] SRSTN;
    logic       RST_DONE;
    logic [1:0] STATE;
    logic [0:0] SRSTN2;
    logic       RST_DONE2;
    logic [1:0] STATE2;

    int nChecks = 0;
    int nBad    = 0;

    reset_seq_sync dut (
        .CLK        (CLK),
        .ARSTN      (ARSTN),
        .SW_RST_REQ (SW_RST_REQ),
        .SRSTN      (SRSTN),
        .RST_DONE   (RST_DONE),
        .STATE      (STATE)
    );

    reset_seq_sync #(
        .NUM_CH            (1),
        .SYNC_STAGES       (3),
        .MIN_ASSERT_CYCLES (1),
        .STAGGER_CYCLES    (1)
    ) dutSmall (
        .CLK        (CLK),
        .ARSTN      (ARSTN),
        .SW_RST_REQ (SW_RST_REQ),
        .SRSTN      (SRSTN2),
        .RST_DONE   (RST_DONE2),
        .STATE      (STATE2)
    );

    // 100 MHz free-running clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walks edges firstK..lastK; bit i of the default DUT is expected high from
    // edge base+4*i, RST_DONE from base+16; the small DUT releases at base2
    // and finishes one edge later. SW_RST_REQ is dropped after edge holdK.
    task automatic checkSeq(input int firstK, input int base, input int base2,
                            input int holdK, input int lastK);
        logic [3:0] eSrstn;
        logic [1:0] eState;
        for (int k = firstK; k <= lastK; k++) begin
            @(posedge CLK);
            #1;
            if (k >= holdK) SW_RST_REQ = 1'b0;
            for (int i = 0; i < 4; i++) eSrstn[i] = (k >= base + 4 * i);
            eState = (k >= base + 16) ? 2'd2 : (k >= base) ? 2'd1 : 2'd0;
            checkOutput($sformatf("srstn k=%0d", k), 32'(SRSTN), 32'(eSrstn));
            checkOutput($sformatf("done k=%0d", k), 32'(RST_DONE), 32'(k >= base + 16));
            checkOutput($sformatf("state k=%0d", k), 32'(STATE), 32'(eState));
            eState = (k >= base2 + 1) ? 2'd2 : (k >= base2) ? 2'd1 : 2'd0;
            checkOutput($sformatf("srstn1 k=%0d", k), 32'(SRSTN2), 32'(k >= base2));
            checkOutput($sformatf("done1 k=%0d", k), 32'(RST_DONE2), 32'(k >= base2 + 1));
            checkOutput($sformatf("state1 k=%0d", k), 32'(STATE2), 32'(eState));
        end
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, " srstn"}, 32'(SRSTN), 32'h0);
        checkOutput({tag, " done"}, 32'(RST_DONE), 32'h0);
        checkOutput({tag, " state"}, 32'(STATE), 32'h0);
        checkOutput({tag, " srstn1"}, 32'(SRSTN2), 32'h0);
        checkOutput({tag, " done1"}, 32'(RST_DONE2), 32'h0);
    endtask

    // Drops ARSTN between clock edges and checks outputs clear without a clock
    task automatic applyStimulus(input string tag);
        ARSTN = 1'b0;
        #1;
        checkAllReset(tag);
        ARSTN = 1'b1;
    endtask

    initial begin
        ARSTN      = 1'b0;
        SW_RST_REQ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkAllReset("por");

        $display("[TB] power-on sequence");
        ARSTN = 1'b1;
        checkSeq(1, 18, 4, -1, 40);

        $display("[TB] async reset from RUN, then mid-RELEASE");
        applyStimulus("arst_run");
        checkSeq(1, 18, 4, -1, 23);
        applyStimulus("arst_rel");
        checkSeq(1, 18, 4, -1, 40);

        $display("[TB] single-cycle software request in RUN");
        SW_RST_REQ = 1'b1;
        checkSeq(0, 16, 1, 0, 36);

        $display("[TB] software request held for 10 cycles");
        SW_RST_REQ = 1'b1;
        checkSeq(0, 25, 10, 9, 45);

        $display("[TB] software request on the SRSTN[2] release edge");
        SW_RST_REQ = 1'b1;
        checkSeq(0, 16, 1, 0, 23);
        SW_RST_REQ = 1'b1;
        checkSeq(0, 16, 1, 0, 34);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/reset_seq_sync.md
Name: reset_seq_sync

Overview:
Parametrised reset synchroniser and release sequencer for the CLK domain. ARSTN is asserted asynchronously and released through a configurable-depth synchroniser. After release, a minimum hold time is enforced, then NUM_CH synchronous active-low resets are released one by one with a fixed stagger. A synchronous software reset request re-enters the sequence without pulsing ARSTN. The block sits at each clock-domain boundary and feeds the per-subsystem resets, for example FIFO write side, read side, datapath and control.

Parameters:
NUM_CH, 4, number of sequenced reset outputs (>=1)
SYNC_STAGES, 2, depth of the ARSTN deassertion synchroniser (>=2)
MIN_ASSERT_CYCLES, 16, CLK cycles held in reset after the synchronised release or a SW request (>=1)
STAGGER_CYCLES, 4, CLK cycles between consecutive channel releases, and from the last channel release to RST_DONE (>=1)

Ports:
CLK  in  1  clock
ARSTN  in  1  asynchronous, active-low reset
SW_RST_REQ  in  1  synchronous software reset request, level-sensitive, CLK domain
SRSTN  out  NUM_CH  active-low synchronous resets; bit 0 is released first
RST_DONE  out  1  high once all channels are released and the stagger has completed
STATE  out  2  debug: 0=HOLD, 1=RELEASE, 2=RUN

Behaviour:
- ARSTN low (async): sync chain = 0, state = HOLD, cnt = 0, ch_idx = 0, SRSTN = 0, RST_DONE = 0, STATE = 0.
  - Applies immediately, at any point mid-sequence.
- Sync chain: SYNC_STAGES flops with async clear, D of the first flop tied to 1.
  - Output arst_sync_n goes high after SYNC_STAGES CLK edges following ARSTN release.
- Counter width is $clog2(max(MIN_ASSERT_CYCLES, STAGGER_CYCLES)+1). It never wraps, because each compare resets it.
- HOLD:
  - If SW_RST_REQ = 1 or arst_sync_n = 0: cnt <= 0.
  - Else if cnt == MIN_ASSERT_CYCLES-1: go to RELEASE, SRSTN[0] <= 1, cnt <= 0, ch_idx <= 0.
  - Else cnt++.
  - SRSTN stays all 0 throughout HOLD.
- RELEASE:
  - If SW_RST_REQ = 1: next edge goes to HOLD with SRSTN = 0, RST_DONE = 0, cnt = 0, ch_idx = 0.
  - Else if cnt == STAGGER_CYCLES-1 and ch_idx == NUM_CH-1: go to RUN, RST_DONE <= 1.
  - Else if cnt == STAGGER_CYCLES-1: ch_idx++, SRSTN[ch_idx+1] <= 1, cnt <= 0.
  - Else cnt++.
- RUN:
  - SRSTN all 1, RST_DONE = 1.
  - SW_RST_REQ = 1 gives the same abort to HOLD as in RELEASE.
- Latency from ARSTN deassert (edge 1 is the first CLK edge after release):
  - arst_sync_n high after edge S = SYNC_STAGES.
  - SRSTN[i] high after edge S + MIN_ASSERT_CYCLES + i*STAGGER_CYCLES.
  - RST_DONE high after edge S + MIN_ASSERT_CYCLES + NUM_CH*STAGGER_CYCLES.
- SW request latency:
  - Request sampled at edge t in RELEASE or RUN: all SRSTN low after edge t.
  - If REQ is 1 only at t: SRSTN[0] high after edge t + MIN_ASSERT_CYCLES.
  - Holding REQ high keeps the block in HOLD. The release count restarts on the first edge where REQ = 0.
- SRSTN bits are only ever released in index order. Once released, a bit stays released until HOLD. SRSTN is monotonic: no glitch and no partial re-assert.
- All outputs are registered; SRSTN and RST_DONE come straight from flops.
- NUM_CH = 1: the block degenerates to sync + stretch, and RST_DONE follows SRSTN[0] by STAGGER_CYCLES.

Test Plan:
- Defaults, ARSTN low for 3 cycles then high:
  - SRSTN[0..3] rise after edges 18, 22, 26, 30.
  - RST_DONE rises after edge 34; STATE goes 0 -> 1 -> 2.
- ARSTN pulsed low for 1 ns mid-RELEASE (after edge 23), between edges:
  - SRSTN = 0 and RST_DONE = 0 immediately, without waiting for CLK.
  - The full sequence restarts and SRSTN[0] rises 18 edges after ARSTN returns high.
- In RUN, SW_RST_REQ high for 1 cycle sampled at edge t:
  - SRSTN = 4'b0000 after t.
  - SRSTN[0] rises after t+16, SRSTN[3] after t+28, RST_DONE after t+32.
- SW_RST_REQ held high 10 cycles (sampled edges t..t+9):
  - Block stays in HOLD.
  - SRSTN[0] rises after edge t+9+16.
- SW_RST_REQ sampled at the same edge where SRSTN[2] would release:
  - Abort wins, and SRSTN[2] never rises.
  - Next edge shows SRSTN = 0; the release order on the re-run is 0, 1, 2, 3.
- Params NUM_CH=1, SYNC_STAGES=3, MIN_ASSERT_CYCLES=1, STAGGER_CYCLES=1:
  - SRSTN[0] rises after edge 4, RST_DONE after edge 5.
